// File: rtl/error_detect.sv
// CAN bit-stuffing error detector: resolves bits (single sample or 2-of-3 vote) and flags runs longer than STUFF_LIMIT.
// Optional macro ERRDET_REARM_EN: errorFrame clears on an opposite bit instead of staying sticky until reset.
module error_detect #(
    parameter int STUFF_LIMIT = 5
) (
    input  logic clk,
    input  logic resetN,
    input  logic dIn,
    input  logic samplePulse,
    input  logic rateSelector,
    output logic errorFrame
);

    localparam int CW = $clog2(STUFF_LIMIT + 2);
    localparam logic [CW-1:0] ERR_COUNT = CW'(STUFF_LIMIT + 1);
    localparam logic [CW-1:0] ONE_COUNT = CW'(1);

    logic          strobe_q, strobe_d;
    logic          rate_q,   rate_d;
    logic [1:0]    idx_q,    idx_d;
    logic [1:0]    acc_q,    acc_d;
    logic [CW-1:0] count_q,  count_d;
    logic          bit_q,    bit_d;
    logic          err_q,    err_d;

    logic sampleEvent;
    logic rateChange;
    logic bitValid;
    logic bitVal;

    assign sampleEvent = samplePulse & ~strobe_q;
    assign rateChange  = rateSelector != rate_q;

    always_comb begin
        strobe_d = samplePulse;
        rate_d   = rateSelector;
        idx_d    = idx_q;
        acc_d    = acc_q;
        count_d  = count_q;
        bit_d    = bit_q;
        err_d    = err_q;
        bitValid = 1'b0;
        bitVal   = dIn;

        // A rate switch throws away any partial vote, including a sample landing on that same edge.
        if (rateChange) begin
            idx_d = 2'd0;
            acc_d = 2'b00;
        end else if (sampleEvent) begin
            if (!rateSelector) begin
                bitValid = 1'b1;
            end else begin
                case (idx_q)
                    2'd0: begin
                        acc_d[0] = dIn;
                        idx_d    = 2'd1;
                    end
                    2'd1: begin
                        acc_d[1] = dIn;
                        idx_d    = 2'd2;
                    end
                    default: begin
                        bitValid = 1'b1;
                        bitVal   = (acc_q[0] & acc_q[1]) | (acc_q[0] & dIn) | (acc_q[1] & dIn);
                        idx_d    = 2'd0;
                        acc_d    = 2'b00;
                    end
                endcase
            end
        end

        if (bitValid) begin
            if (count_q == '0 || bitVal != bit_q) begin
                count_d = ONE_COUNT;
                bit_d   = bitVal;
`ifdef ERRDET_REARM_EN
                err_d   = 1'b0;
`endif
            end else if (count_q != ERR_COUNT) begin
                count_d = count_q + ONE_COUNT;
            end
            if (count_d == ERR_COUNT) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            strobe_q <= 1'b0;
            rate_q   <= rateSelector;
            idx_q    <= 2'd0;
            acc_q    <= 2'b00;
            count_q  <= '0;
            bit_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
            rate_q   <= rate_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            bit_q    <= bit_d;
            err_q    <= err_d;
        end
    end

    assign errorFrame = err_q;

endmodule

// File: tb/tb_error_detect.sv
// Directed self-checking bench for error_detect; expectations follow ERRDET_REARM_EN when it is defined.
module tb_error_detect;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic dIn = 1'b1;
    logic samplePulse = 1'b0;
    logic rateSelector = 1'b0;
    logic errorFrame;
    logic errAtEdge;

    int assertions = 0;
    int failures = 0;

    error_detect #(.STUFF_LIMIT(5)) dut (
        .clk(clk),
        .resetN(resetN),
        .dIn(dIn),
        .samplePulse(samplePulse),
        .rateSelector(rateSelector),
        .errorFrame(errorFrame)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: errorFrame=%b expected=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        resetN = 1'b0;
        samplePulse = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    // One strobe held `hold` cycles; errOut is errorFrame just after the rising-edge sample.
    task automatic applyStimulus(input logic b, input int hold, output logic errOut);
        @(negedge clk);
        dIn = b;
        samplePulse = 1'b1;
        @(posedge clk);
        #1;
        errOut = errorFrame;
        for (int i = 1; i < hold; i++) @(posedge clk);
        @(negedge clk);
        samplePulse = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: errorFrame=%b expected=finish", errorFrame);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyReset();
        #1;
        checkOutput("reset", errorFrame, 1'b0);

        // T1: five 1s then a 0, then prove the run restarted at 1
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1, errAtEdge);
            checkOutput($sformatf("T1 one%0d", i), errAtEdge, 1'b0);
        end
        applyStimulus(1'b0, 1, errAtEdge);
        checkOutput("T1 zero", errAtEdge, 1'b0);
        for (int i = 2; i <= 6; i++) begin
            applyStimulus(1'b0, 1, errAtEdge);
            checkOutput($sformatf("T1 zeroRun%0d", i), errAtEdge, (i == 6));
        end

        // T2 and T3
        applyReset();
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 1, errAtEdge);
            checkOutput($sformatf("T2 s%0d", i), errAtEdge, (i >= 6));
        end
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 1, errAtEdge);
`ifdef ERRDET_REARM_EN
            checkOutput($sformatf("T3 s%0d", i), errAtEdge, (i >= 6));
`else
            checkOutput($sformatf("T3 s%0d", i), errAtEdge, 1'b1);
`endif
        end

        // T4: majority mode, every bit is 1,0,1
        @(negedge clk);
        rateSelector = 1'b1;
        applyReset();
        for (int i = 1; i <= 18; i++) begin
            applyStimulus((i % 3) != 2, 1, errAtEdge);
            checkOutput($sformatf("T4 s%0d", i), errAtEdge, (i == 18));
        end

        // Partial vote discarded by a rate toggle
        applyReset();
        applyStimulus(1'b0, 1, errAtEdge);
        applyStimulus(1'b0, 1, errAtEdge);
        @(negedge clk);
        rateSelector = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rateSelector = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 1; i <= 18; i++) begin
            applyStimulus(1'b1, 1, errAtEdge);
            if (i % 3 == 0) checkOutput($sformatf("rate s%0d", i), errAtEdge, (i == 18));
        end

        // T5: strobe held high four cycles counts once
        @(negedge clk);
        rateSelector = 1'b0;
        applyReset();
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 4, errAtEdge);
            checkOutput($sformatf("T5 edge%0d", i), errAtEdge, (i == 6));
            checkOutput($sformatf("T5 hold%0d", i), errorFrame, (i == 6));
        end

        // T6: reset mid-run clears the flag and the run
        applyReset();
        for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 1, errAtEdge);
        checkOutput("T6 preReset", errorFrame, 1'b1);
        applyReset();
        #1;
        checkOutput("T6 afterReset", errorFrame, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 1, errAtEdge);
            checkOutput($sformatf("T6 s%0d", i), errAtEdge, (i == 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
